// File: rtl/wb_rc_capture_pkg.sv
// wb_rc_capture_pkg: register map, channel sizing and channel state type for the RC capture block.
package wb_rc_capture_pkg;
    localparam int CH_NUM = 4;
    localparam int WIDTH_W = 16;
    localparam logic [2:0] ADR_STATUS = 3'd0;
    localparam logic [2:0] ADR_WIDTH0 = 3'd1;
    localparam logic [2:0] ADR_WIDTH1 = 3'd2;
    localparam logic [2:0] ADR_WIDTH2 = 3'd3;
    localparam logic [2:0] ADR_WIDTH3 = 3'd4;
    localparam logic [2:0] ADR_CTRL = 3'd5;
    localparam logic [2:0] ADR_ERR = 3'd6;
    typedef enum logic {WAIT_RISE, MEASURE} ch_state_e;
endpackage

// File: rtl/wb_rc_capture_ch.sv
// wb_rc_capture_ch: one RC channel - synchroniser, edge detect, high-time FSM, range check, loss timeout.
module rc_capture_ch
    import wb_rc_capture_pkg::*;
#(
    parameter int MIN_WIDTH_US = 800,
    parameter int MAX_WIDTH_US = 2200,
    parameter int TIMEOUT_US = 100000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rc_i,
    input  logic               tick_i,
    input  logic               en_i,
    output logic               valid_o,
    output logic               lost_o,
    output logic               err_o,
    output logic [WIDTH_W-1:0] width_o
);
    localparam logic [WIDTH_W-1:0] MIN_W = WIDTH_W'(MIN_WIDTH_US);
    localparam logic [WIDTH_W-1:0] MAX_W = WIDTH_W'(MAX_WIDTH_US);
    localparam logic [WIDTH_W-1:0] CNT_SAT = WIDTH_W'(MAX_WIDTH_US + 1);
    localparam logic [16:0] TO_MAX = 17'(TIMEOUT_US);

    ch_state_e state_q, state_d;
    logic [2:0] sync_q;
    logic [WIDTH_W-1:0] cnt_q, cnt_d, width_q, width_d;
    logic [16:0] to_q, to_d;
    logic valid_q, valid_d, lost_q, lost_d;
    logic rise, fall, in_range;

    // sync_q = {edge reference, 2nd sync, 1st sync}; all reset high so a line high at reset is no rise
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];
    assign in_range = cnt_q >= MIN_W && cnt_q <= MAX_W;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        width_d = width_q;
        valid_d = valid_q;
        lost_d = lost_q;
        to_d = to_q;
        err_o = 1'b0;
        if (!en_i) begin
            state_d = WAIT_RISE;
        end else begin
            to_d = tick_i && to_q != TO_MAX ? to_q + 17'd1 : to_q;
            if (to_q == TO_MAX) begin
                valid_d = 1'b0;
                lost_d = 1'b1;
            end
            if (state_q == WAIT_RISE) begin
                if (rise) begin
                    cnt_d = '0;
                    state_d = MEASURE;
                end
            end else if (fall) begin
                state_d = WAIT_RISE;
                if (in_range) begin
                    width_d = cnt_q;
                    valid_d = 1'b1;
                    lost_d = 1'b0;
                    to_d = '0;
                end else begin
                    err_o = 1'b1;
                end
            end else if (tick_i && cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_RISE;
            sync_q <= 3'b111;
            cnt_q <= '0;
            width_q <= '0;
            to_q <= '0;
            valid_q <= 1'b0;
            lost_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q <= {sync_q[1:0], rc_i};
            cnt_q <= cnt_d;
            width_q <= width_d;
            to_q <= to_d;
            valid_q <= valid_d;
            lost_q <= lost_d;
        end
    end

    assign valid_o = valid_q;
    assign lost_o = lost_q;
    assign width_o = width_q;
endmodule

// File: rtl/wb_rc_capture.sv
// wb_rc_capture: Wishbone slave measuring the high time in us of four RC receiver PWM inputs.
module wb_rc_capture
    import wb_rc_capture_pkg::*;
#(
    parameter int CLKS_PER_US = 50,
    parameter int MIN_WIDTH_US = 800,
    parameter int MAX_WIDTH_US = 2200,
    parameter int TIMEOUT_US = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  rc_in
);
    localparam int PW = CLKS_PER_US > 1 ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_US - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [CH_NUM-1:0] en_q, en_d, err_q, err_d, clr, err_p, valid, lost;
    logic [WIDTH_W-1:0] width [CH_NUM];
    logic [31:0] dat_q, dat_d, rdata;
    logic ack_q, req, acc, wr, tick;
    logic [2:0] sel;
    logic [1:0] wi;
    logic unused_bits;

    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:12], wb_dat_i[7:4]};

    assign tick = pre_q == PRE_LAST;
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        rc_capture_ch #(
            .MIN_WIDTH_US(MIN_WIDTH_US),
            .MAX_WIDTH_US(MAX_WIDTH_US),
            .TIMEOUT_US(TIMEOUT_US)
        ) u_ch (
            .clk(clk),
            .reset(reset),
            .rc_i(rc_in[n]),
            .tick_i(tick),
            .en_i(en_q[n]),
            .valid_o(valid[n]),
            .lost_o(lost[n]),
            .err_o(err_p[n]),
            .width_o(width[n])
        );
    end

    // accesses take effect in the clk that raises ack; ack_q blocks a back-to-back ack
    assign req = wb_stb_i & wb_cyc_i;
    assign acc = req & ~ack_q;
    assign wr = acc & wb_we_i;
    assign sel = wb_adr_i[4:2];
    assign wi = 2'(sel - ADR_WIDTH0);

    always_comb begin
        en_d = wr && sel == ADR_CTRL ? wb_dat_i[3:0] : en_q;
        clr = wr && sel == ADR_CTRL ? wb_dat_i[11:8] : '0;
        err_d = (err_q & ~clr) | err_p;
        rdata = sel == ADR_STATUS ? {24'd0, lost, valid}
              : sel == ADR_CTRL ? {28'd0, en_q}
              : sel == ADR_ERR ? {28'd0, err_q}
              : sel >= ADR_WIDTH0 && sel <= ADR_WIDTH3 ? {{(32 - WIDTH_W){1'b0}}, width[wi]}
              : 32'd0;
        dat_d = acc && !wb_we_i ? rdata : dat_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
            en_q <= 4'hF;
            err_q <= '0;
            dat_q <= '0;
            ack_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            en_q <= en_d;
            err_q <= err_d;
            dat_q <= dat_d;
            ack_q <= acc;
        end
    end

    assign wb_ack_o = req & ack_q;
    assign wb_dat_o = dat_q;
endmodule

// File: tb/tb_wb_rc_capture.sv
// tb_wb_rc_capture: directed checks of capture, range errors, timeout, enable gating and bus timing.
module tb_wb_rc_capture;
    localparam int C = 2;
    localparam int TO = 3000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stb = 1'b0, cyc = 1'b0, we = 1'b0, ack;
    logic [31:0] adr = '0, wdat = '0, rdat;
    logic [3:0] sel = 4'hF;
    logic [3:0] rc = 4'hF;
    logic [31:0] d;
    logic a1, a2, a3;
    int e_cnt = 0;
    int n_chk = 0;
    int n_fail = 0;

    wb_rc_capture #(.CLKS_PER_US(C), .TIMEOUT_US(TO)) dut (
        .clk(clk), .reset(reset), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack),
        .wb_we_i(we), .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_dat_o(rdat),
        .rc_in(rc)
    );

    always #5 clk = ~clk;

    // index of the next active edge counted from the first edge out of reset (prescaler phase)
    always @(posedge clk) e_cnt <= reset ? 0 : e_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a;
        @(posedge clk);
        #1;
        check("rd_ack", {31'd0, ack}, 32'd1);
        v = rdat;
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; wdat = v;
        @(posedge clk);
        #1;
        check("wr_ack", {31'd0, ack}, 32'd1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_us(input int us);
        repeat (us * C) @(negedge clk);
    endtask

    // stop on a negedge whose edges 2 later land (on_tick=1) or not (on_tick=0) on a tick clk
    task automatic align(input bit on_tick);
        @(negedge clk);
        while ((((e_cnt + 2) % C) == C - 1) != on_tick) @(negedge clk);
    endtask

    task automatic pulse(input int ch, input int us, input bit on_tick);
        align(on_tick);
        rc[ch] = 1'b1;
        wait_us(us);
        rc[ch] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_dat", rdat, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        wb_read(32'h00, d); check("rst_status", d, 32'h0);
        wb_read(32'h14, d); check("rst_ctrl", d, 32'hF);
        wb_read(32'h18, d); check("rst_err", d, 32'h0);
        wb_read(32'h04, d); check("rst_w0", d, 32'h0);
        wait_us(10);
        rc = 4'h0;
        wait_us(10);
        wb_read(32'h00, d); check("held_hi_status", d, 32'h0);
        wb_read(32'h18, d); check("held_hi_err", d, 32'h0);

        pulse(0, 1500, 1'b0);
        wb_read(32'h04, d); check("w0_1500", d, 32'd1500);
        wb_read(32'h00, d); check("status_ch0", d, 32'h01);

        pulse(1, 700, 1'b0);
        wb_read(32'h18, d); check("err_short", d, 32'h2);
        wb_read(32'h08, d); check("w1_short", d, 32'h0);
        wb_read(32'h00, d); check("v1_short", d & 32'h2, 32'h0);
        wb_write(32'h14, 32'h20F);
        wb_read(32'h18, d); check("err_clr1", d, 32'h0);
        pulse(1, 2500, 1'b0);
        wb_read(32'h18, d); check("err_long", d, 32'h2);
        wb_read(32'h08, d); check("w1_long", d, 32'h0);
        wb_write(32'h14, 32'h20F);
        wb_read(32'h18, d); check("err_clr2", d, 32'h0);
        pulse(1, 800, 1'b0);
        wb_read(32'h08, d); check("w1_min", d, 32'd800);
        pulse(1, 2200, 1'b0);
        wb_read(32'h08, d); check("w1_max", d, 32'd2200);
        wb_read(32'h18, d); check("err_bounds", d, 32'h0);

        pulse(2, 1000, 1'b0);
        wait_us(1000);
        pulse(2, 1000, 1'b0);
        wb_read(32'h0C, d); check("w2_1000", d, 32'd1000);
        wb_read(32'h00, d); check("st2_valid", d & 32'h44, 32'h04);
        wait_us(3100);
        wb_read(32'h00, d); check("st2_lost", d & 32'h44, 32'h40);
        wb_read(32'h0C, d); check("w2_kept", d, 32'd1000);
        pulse(2, 1200, 1'b0);
        wb_read(32'h00, d); check("st2_back", d & 32'h44, 32'h04);
        wb_read(32'h0C, d); check("w2_1200", d, 32'd1200);

        align(1'b1);
        rc[3] = 1'b1;
        wait_us(1200);
        rc[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h10;
        @(posedge clk);
        #1;
        check("w3_same_clk_ack", {31'd0, ack}, 32'd1);
        check("w3_same_clk_old", rdat, 32'd0);
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        wb_read(32'h10, d); check("w3_fall_wins", d, 32'd1199);
        wb_read(32'h00, d); check("st3_valid", d & 32'h88, 32'h08);

        wb_write(32'h14, 32'h007);
        pulse(3, 1500, 1'b0);
        pulse(3, 500, 1'b0);
        wait_us(3500);
        wb_read(32'h10, d); check("w3_disabled", d, 32'd1199);
        wb_read(32'h18, d); check("err_disabled", d, 32'h0);
        wb_read(32'h00, d); check("st3_frozen", d & 32'h88, 32'h08);
        wb_write(32'h14, 32'h00F);
        pulse(3, 1300, 1'b0);
        wb_read(32'h10, d); check("w3_reenabled", d, 32'd1300);

        wb_read(32'h1C, d); check("unmapped_rd", d, 32'h0);
        wb_write(32'h04, 32'hFFFF);
        wb_read(32'h04, d); check("ro_write", d, 32'd1500);
        wb_read(32'h14, d); check("ctrl_rd", d, 32'hF);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h00;
        @(posedge clk); #1; a1 = ack;
        @(posedge clk); #1; a2 = ack;
        @(posedge clk); #1; a3 = ack;
        stb = 1'b0; cyc = 1'b0;
        check("ack_hold", {29'd0, a1, a2, a3}, 32'b101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
